adder_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined DATA_W-bit full adder among N_REQ requesters. Each requester offers an operand pair and carry-in through a valid/ready handshake; the block grants one request per cycle and pushes it through a two-stage registered adder. It returns sum, carry-out and requester ID on a single response port with backpressure. The block sits between the per-channel datapath front ends and the shared arithmetic resource, on the negative clock edge.

---
 rtl/adder_share_arbiter_if.sv | 29 ++
 rtl/adder_share_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle for adder_share_arbiter.
// The master drives requests and consumes responses. The slave is the arbiter.
interface adder_share_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int N_REQ  = 4,
    parameter int ID_W   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ-1:0]        req_cin;
    logic [N_REQ-1:0]        req_chain;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_sum;
    logic                    rsp_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin arbiter that feeds one shared two-stage
// pipelined adder from N_REQ requesters. Results leave on a single response
// port that supports backpressure. All state changes on negedge clk.
// Optional feature macro ADD_ARB_CARRY_CHAIN_EN adds per-requester carry
// registers. These are loaded from completed responses and selected by
// req_chain for multi-word adds.
module adder_share_arbiter #(
    parameter int DATA_W = 16,
    parameter int N_REQ  = 4,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input logic                  clk,
    input logic                  rst,
    adder_share_arbiter_if.slave bus
);

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s1_b_q, s1_b_d;
    logic              s1_cin_q, s1_cin_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_sum_q, rsp_sum_d;
    logic              rsp_cout_q, rsp_cout_d;

    logic              stall;
    logic              accept;
    logic [N_REQ-1:0]  eligible;
    logic              gnt_valid;
    logic [ID_W-1:0]   gnt_id;
    logic [DATA_W-1:0] gnt_a;
    logic [DATA_W-1:0] gnt_b;
    logic              gnt_cin;
    logic [N_REQ-1:0]  ready;
    logic [DATA_W:0]   s1_total;

`ifdef ADD_ARB_CARRY_CHAIN_EN
    logic [N_REQ-1:0]  cy_q, cy_d;
`else
    logic              unused_chain;
    assign unused_chain = ^bus.req_chain;
`endif

    assign stall    = rsp_valid_q && !bus.rsp_ready;
    assign accept   = gnt_valid && !stall && !rst;
    assign s1_total = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{DATA_W{1'b0}}, s1_cin_q};

    // Requests that may compete this cycle.
    // A chained request waits while its own earlier op is still in flight.
    always_comb begin
        eligible = bus.req_valid;
`ifdef ADD_ARB_CARRY_CHAIN_EN
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.req_chain[i] &&
                ((s1_valid_q && s1_id_q == ID_W'(i)) ||
                 (rsp_valid_q && rsp_id_q == ID_W'(i)))) begin
                eligible[i] = 1'b0;
            end
        end
`endif
    end

    // Round-robin search from ptr_q; the first eligible requester wins
    always_comb begin
        int unsigned idx;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        gnt_a     = '0;
        gnt_b     = '0;
        gnt_cin   = 1'b0;
        idx       = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!gnt_valid && eligible[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = ID_W'(idx);
                gnt_a     = bus.req_a[idx*DATA_W +: DATA_W];
                gnt_b     = bus.req_b[idx*DATA_W +: DATA_W];
`ifdef ADD_ARB_CARRY_CHAIN_EN
                gnt_cin   = bus.req_chain[idx] ? cy_q[idx] : bus.req_cin[idx];
`else
                gnt_cin   = bus.req_cin[idx];
`endif
            end
        end
    end

    // One-hot ready towards the winner, only when the accept can happen
    always_comb begin
        ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            ready[i] = accept && (gnt_id == ID_W'(i));
        end
    end

    // Pipeline advance, pointer update and carry capture
    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_cin_d    = s1_cin_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
`ifdef ADD_ARB_CARRY_CHAIN_EN
        cy_d        = cy_q;
        if (rsp_valid_q && bus.rsp_ready) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (rsp_id_q == ID_W'(i)) begin
                    cy_d[i] = rsp_cout_q;
                end
            end
        end
`endif
        if (!stall) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_sum_d  = s1_total[DATA_W-1:0];
                rsp_cout_d = s1_total[DATA_W];
                rsp_id_d   = s1_id_q;
            end
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_a_d   = gnt_a;
            s1_b_d   = gnt_b;
            s1_cin_d = gnt_cin;
            s1_id_d  = gnt_id;
            if (gnt_id == ID_W'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(negedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cin_q    <= 1'b0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
`ifdef ADD_ARB_CARRY_CHAIN_EN
            cy_q        <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_cin_q    <= s1_cin_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
`ifdef ADD_ARB_CARRY_CHAIN_EN
            cy_q        <= cy_d;
`endif
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter. It runs directed scenarios
// followed by a randomized run that is checked against a transaction-level
// reference model.
module tb_adder_share_arbiter;
    localparam int DATA_W = 16;
    localparam int N_REQ  = 4;
    localparam int ID_W   = 2;
`ifdef ADD_ARB_CARRY_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    adder_share_arbiter_if #(.DATA_W(DATA_W), .N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    adder_share_arbiter #(.DATA_W(DATA_W), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: two pipeline slots, each holding a finished result
    int              m_ptr;
    bit              m_s1_v, m_s2_v;
    int              m_s1_id, m_s2_id;
    logic [DATA_W:0] m_s1_res, m_s2_res;
    bit [N_REQ-1:0]  m_cy;

    function automatic logic [DATA_W:0] add_ref(input logic [DATA_W-1:0] a, b, input logic c);
        return (DATA_W+1)'(a) + (DATA_W+1)'(b) + (DATA_W+1)'(c);
    endfunction

    function automatic int predict_grant();
        int i;
        bit blocked;
        if (rst) return -1;
        if (m_s2_v && !bus.rsp_ready) return -1;
        for (int k = 0; k < N_REQ; k++) begin
            i = (m_ptr + k) % N_REQ;
            blocked = CHAIN && bus.req_chain[i] &&
                      ((m_s1_v && m_s1_id == i) || (m_s2_v && m_s2_id == i));
            if (bus.req_valid[i] && !blocked) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input int g);
        logic c;
        logic [DATA_W:0] res;
        if (rst) begin
            m_ptr = 0; m_s1_v = 0; m_s2_v = 0; m_cy = '0;
            return;
        end
        res = '0;
        if (g >= 0) begin
            c = (CHAIN && bus.req_chain[g]) ? m_cy[g] : bus.req_cin[g];
            res = add_ref(bus.req_a[g*DATA_W +: DATA_W], bus.req_b[g*DATA_W +: DATA_W], c);
        end
        if (m_s2_v && bus.rsp_ready) m_cy[m_s2_id] = m_s2_res[DATA_W];
        if (!(m_s2_v && !bus.rsp_ready)) begin
            m_s2_v = m_s1_v; m_s2_id = m_s1_id; m_s2_res = m_s1_res;
            m_s1_v = (g >= 0); m_s1_id = g; m_s1_res = res;
        end
        if (g >= 0) m_ptr = (g + 1) % N_REQ;
    endtask

    task automatic set_req(input int i, input logic [DATA_W-1:0] a, b, input logic cin, chain);
        bus.req_a[i*DATA_W +: DATA_W] = a;
        bus.req_b[i*DATA_W +: DATA_W] = b;
        bus.req_cin[i]   = cin;
        bus.req_chain[i] = chain;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        model_edge(-1);
        @(posedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        model_edge(-1);
        @(posedge clk);
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
        checks++; if (bus.rsp_sum !== 16'h0000) begin failures++; $display("FAIL reset_rsp_sum: got %h want 0000", bus.rsp_sum); end
        checks++; if (bus.rsp_cout !== 1'b0) begin failures++; $display("FAIL reset_rsp_cout: got %b want 0", bus.rsp_cout); end
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant: got %b want 0001", bus.req_ready); end
        bus.req_valid = '0;
        @(negedge clk);
        @(posedge clk);
        do_reset();
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'h8000};
        logic [DATA_W-1:0] vb [3] = '{16'h0F0F, 16'hFFFF, 16'h8000};
        logic              vc [3] = '{1'b1, 1'b1, 1'b0};
        logic [DATA_W-1:0] es [3] = '{16'h2144, 16'hFFFF, 16'h0000};
        logic              ec [3] = '{1'b0, 1'b1, 1'b1};
        bus.rsp_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            set_req(2, va[v], vb[v], vc[v], 1'b0);
            bus.req_valid = 4'b0100;
            #1;
            checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready[%0d]: got %b want 0100", v, bus.req_ready); end
            @(negedge clk);
            @(posedge clk);
            bus.req_valid = '0;
            checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early[%0d]: rsp_valid got %b want 0", v, bus.rsp_valid); end
            @(negedge clk);
            @(posedge clk);
            checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid[%0d]: got %b want 1", v, bus.rsp_valid); end
            checks++; if (bus.rsp_id !== 2'd2) begin failures++; $display("FAIL single_id[%0d]: got %0d want 2", v, bus.rsp_id); end
            checks++; if (bus.rsp_sum !== es[v]) begin failures++; $display("FAIL single_sum[%0d]: got %h want %h", v, bus.rsp_sum, es[v]); end
            checks++; if (bus.rsp_cout !== ec[v]) begin failures++; $display("FAIL single_cout[%0d]: got %b want %b", v, bus.rsp_cout, ec[v]); end
        end
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic test_round_robin();
        logic [DATA_W-1:0] a [N_REQ];
        logic [DATA_W-1:0] b [N_REQ];
        logic [DATA_W:0]   r;
        logic [3:0]        e;
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            a[i] = DATA_W'($urandom);
            b[i] = DATA_W'($urandom);
            set_req(i, a[i], b[i], 1'b0, 1'b0);
        end
        bus.req_valid = 4'b1111;
        for (int k = 0; k <= 8; k++) begin
            if (k == 8) bus.req_valid = '0;
            #1;
            if (k < 8) begin
                e = 4'b0001 << (k % 4);
                checks++; if (bus.req_ready !== e) begin failures++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.req_ready, e); end
            end
            @(negedge clk);
            @(posedge clk);
            if (k >= 1) begin
                r = add_ref(a[(k-1)%4], b[(k-1)%4], 1'b0);
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'((k-1)%4) || bus.rsp_sum !== r[DATA_W-1:0] || bus.rsp_cout !== r[DATA_W])
                    begin failures++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d sum=%h c=%b want v=1 id=%0d sum=%h c=%b",
                        k-1, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, (k-1)%4, r[DATA_W-1:0], r[DATA_W]); end
            end
        end
        @(negedge clk);
        @(posedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rr_drain: rsp_valid got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_back_pressure();
        logic [DATA_W:0] r0, r1;
        do_reset();
        set_req(0, DATA_W'($urandom), DATA_W'($urandom), 1'b1, 1'b0);
        set_req(1, DATA_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
        r0 = add_ref(bus.req_a[0 +: DATA_W], bus.req_b[0 +: DATA_W], 1'b1);
        r1 = add_ref(bus.req_a[DATA_W +: DATA_W], bus.req_b[DATA_W +: DATA_W], 1'b0);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        @(posedge clk);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        @(posedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin bus.rsp_ready = 1'b1; bus.req_valid = '0; end
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== r0[DATA_W-1:0] || bus.rsp_cout !== r0[DATA_W])
                begin failures++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%h c=%b want v=1 id=0 sum=%h c=%b",
                    k, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, r0[DATA_W-1:0], r0[DATA_W]); end
            #1;
            if (k < 3) begin
                checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, bus.req_ready); end
            end
            @(negedge clk);
            @(posedge clk);
        end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_sum !== r1[DATA_W-1:0] || bus.rsp_cout !== r1[DATA_W])
            begin failures++; $display("FAIL bp_second: got v=%b id=%0d sum=%h c=%b want v=1 id=1 sum=%h c=%b",
                bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, r1[DATA_W-1:0], r1[DATA_W]); end
        @(negedge clk);
        @(posedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup: rsp_valid got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, DATA_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        @(posedge clk);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        @(posedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_full: rsp_valid got %b want 1", bus.rsp_valid); end
        rst = 1'b1;
        bus.req_valid = 4'b1001;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL mid_rst_ready: got %b want 0000", bus.req_ready); end
        @(negedge clk);
        @(posedge clk);
        rst = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 16'h0 || bus.rsp_cout !== 1'b0)
            begin failures++; $display("FAIL mid_cleared: got v=%b id=%0d sum=%h c=%b want all 0",
                bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout); end
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ptr: got %b want 0001", bus.req_ready); end
        @(negedge clk);
        @(posedge clk);
        bus.req_valid = '0;
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_dropped: rsp_valid got %b want 0", bus.rsp_valid); end
        @(negedge clk);
        @(posedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin failures++; $display("FAIL mid_after: got v=%b id=%0d want v=1 id=0", bus.rsp_valid, bus.rsp_id); end
        @(negedge clk);
        @(posedge clk);
    endtask

`ifdef ADD_ARB_CARRY_CHAIN_EN
    task automatic test_chain();
        do_reset();
        set_req(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        bus.req_valid = 4'b0010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL chain_first: got %b want 0010", bus.req_ready); end
        @(negedge clk);
        @(posedge clk);
        set_req(1, 16'h0000, 16'h0000, 1'b0, 1'b1);
        set_req(3, 16'h0005, 16'h0003, 1'b0, 1'b0);
        bus.req_valid = 4'b1010;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL chain_hold_s1: got %b want 1000", bus.req_ready); end
        @(negedge clk);
        @(posedge clk);
        bus.req_valid = 4'b0010;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_sum !== 16'h0000 || bus.rsp_cout !== 1'b1)
            begin failures++; $display("FAIL chain_rsp1: got v=%b id=%0d sum=%h c=%b want v=1 id=1 sum=0000 c=1",
                bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout); end
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL chain_hold_s2: got %b want 0000", bus.req_ready); end
        @(negedge clk);
        @(posedge clk);
        checks++; if (bus.rsp_id !== 2'd3 || bus.rsp_sum !== 16'h0008) begin failures++; $display("FAIL chain_other: got id=%0d sum=%h want id=3 sum=0008", bus.rsp_id, bus.rsp_sum); end
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL chain_release: got %b want 0010", bus.req_ready); end
        @(negedge clk);
        @(posedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        @(posedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_sum !== 16'h0001 || bus.rsp_cout !== 1'b0)
            begin failures++; $display("FAIL chain_rsp2: got v=%b id=%0d sum=%h c=%b want v=1 id=1 sum=0001 c=0",
                bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout); end
        @(negedge clk);
        @(posedge clk);
    endtask
`endif

    task automatic test_random();
        int g;
        int last_g;
        logic [3:0] e;
        do_reset();
        last_g = -1;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!bus.req_valid[i] || last_g == i) begin
                    set_req(i, DATA_W'($urandom), DATA_W'($urandom), 1'($urandom), 1'($urandom));
                    bus.req_valid[i] = ($urandom_range(0, 99) < 60);
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            #1;
            g = predict_grant();
            e = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            checks++; if (bus.req_ready !== e) begin failures++; $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.req_ready, e); end
            @(negedge clk);
            model_edge(g);
            last_g = g;
            @(posedge clk);
            checks++; if (bus.rsp_valid !== m_s2_v) begin failures++; $display("FAIL rand_valid[%0d]: got %b want %b", c, bus.rsp_valid, m_s2_v); end
            if (m_s2_v) begin
                checks++; if (bus.rsp_id !== ID_W'(m_s2_id) || bus.rsp_sum !== m_s2_res[DATA_W-1:0] || bus.rsp_cout !== m_s2_res[DATA_W])
                    begin failures++; $display("FAIL rand_rsp[%0d]: got id=%0d sum=%h c=%b want id=%0d sum=%h c=%b",
                        c, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, m_s2_id, m_s2_res[DATA_W-1:0], m_s2_res[DATA_W]); end
            end
        end
        rst = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.req_chain = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_reset_mid();
`ifdef ADD_ARB_CARRY_CHAIN_EN
        test_chain();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
